// File: rtl/spi_rgb_pkg.sv
// Shared command codes, FSM states and channel indices for the SPI RGB register front-end.
// Pure declarations; no latency or flow control of its own.
package spi_rgb_pkg;

    localparam logic [7:0] CMD_WR_ALL = 8'h80;
    localparam logic [7:0] CMD_WR_R   = 8'h81;
    localparam logic [7:0] CMD_WR_G   = 8'h82;
    localparam logic [7:0] CMD_WR_B   = 8'h83;
    localparam logic [7:0] CMD_RD     = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int CH_R   = 0;
    localparam int CH_G   = 1;
    localparam int CH_B   = 2;
    localparam int NUM_CH = 3;

    // Channels a write command touches; zero for read and illegal commands.
    function automatic logic [NUM_CH-1:0] wr_mask(input logic [7:0] cmd);
        case (cmd)
            CMD_WR_ALL: wr_mask = 3'b111;
            CMD_WR_R:   wr_mask = 3'b001;
            CMD_WR_G:   wr_mask = 3'b010;
            CMD_WR_B:   wr_mask = 3'b100;
            default:    wr_mask = 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] bytes_needed(input logic [7:0] cmd);
        case (cmd)
            CMD_WR_ALL, CMD_RD:           bytes_needed = 2'd3;
            CMD_WR_R, CMD_WR_G, CMD_WR_B: bytes_needed = 2'd1;
            default:                      bytes_needed = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/spi_rgb_regs_sync_edge.sv
// Synchronizer (SYNC_STAGES flops, legal 2..3) plus rise/fall detect for an asynchronous pin.
// Edge pulses are combinational off the last stage: SYNC_STAGES cycles after the pin edge; no backpressure.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Resetting to 0 means a pin already low (e.g. cs_n mid-frame) produces no falling edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_rgb_regs.sv
// SPI mode-0 slave holding R/G/B duties; commits shadows with one-cycle load strobes on a complete frame.
// Commit/error SYNC_STAGES+1 clk after cs_n rises at the pin; no backpressure (host pacing bounded by SCLK rules).
module spi_rgb_regs
    import spi_rgb_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic [7:0] duty_r,
    output logic [7:0] duty_g,
    output logic [7:0] duty_b,
    output logic       load_r,
    output logic       load_g,
    output logic       load_b,
    output logic       frame_err
);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_i  (spi_sclk),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_i  (spi_cs_n),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    // Same depth as the SCLK chain, so mosi_s is the pin value at the recognised SCLK edge.
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   mosi_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mosi_sync_q <= '0;
        else        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    state_e                  state_q, state_d;
    logic [2:0]              bit_cnt_q, bit_cnt_d;
    logic [1:0]              byte_cnt_q, byte_cnt_d;
    logic [6:0]              rx_q, rx_d;
    logic [7:0]              cmd_q, cmd_d;
    logic [7:0]              tx_q, tx_d;
    logic [NUM_CH-1:0][7:0]  shadow_q, shadow_d;
    logic [NUM_CH-1:0][7:0]  duty_q, duty_d;
    logic [NUM_CH-1:0]       load_q, load_d;
    logic                    err_q, err_d;
    logic                    miso_q, miso_d;

    logic [7:0]        rx_byte;
    logic [NUM_CH-1:0] mask;
    logic [1:0]        req;
    logic [1:0]        byte_cnt_inc;

    assign rx_byte      = {rx_q, mosi_s};
    assign mask         = wr_mask(cmd_q);
    assign req          = bytes_needed(cmd_q);
    assign byte_cnt_inc = (byte_cnt_q == 2'd3) ? 2'd3 : byte_cnt_q + 2'd1;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        rx_d       = rx_q;
        cmd_d      = cmd_q;
        tx_d       = tx_q;
        shadow_d   = shadow_q;
        duty_d     = duty_q;
        load_d     = '0;
        err_d      = 1'b0;
        miso_d     = miso_q;

        // cs_n release outranks any SCLK edge recognised in the same cycle.
        if (cs_rise) begin
            state_d  = IDLE;
            shadow_d = '0;
            miso_d   = 1'b0;
            case (state_q)
                CMD: err_d = (bit_cnt_q != 3'd0);
                DATA, DRAIN: begin
                    if (mask != '0) begin
                        if (byte_cnt_q >= req && bit_cnt_q == 3'd0) begin
                            load_d = mask;
                            for (int ch = 0; ch < NUM_CH; ch++) begin
                                if (mask[ch]) duty_d[ch] = shadow_q[ch];
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (cmd_q != CMD_RD) begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (cs_fall) begin
            state_d    = CMD;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 2'd0;
            shadow_d   = '0;
            miso_d     = 1'b0;
        end else if (state_q != IDLE) begin
            if (sclk_rise) begin
                rx_d      = rx_byte[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    if (state_q == CMD) begin
                        cmd_d = rx_byte;
                        if (wr_mask(rx_byte) != '0 || rx_byte == CMD_RD) state_d = DATA;
                        else                                                state_d = DRAIN;
                        tx_d = duty_q[CH_R];
                    end else if (state_q == DATA) begin
                        byte_cnt_d = byte_cnt_inc;
                        for (int ch = 0; ch < NUM_CH; ch++) begin
                            if ((cmd_q == CMD_WR_ALL) ? (2'(ch) == byte_cnt_q) : mask[ch])
                                shadow_d[ch] = rx_byte;
                            if (2'(ch) == byte_cnt_inc)
                                tx_d = duty_q[ch];
                        end
                        if (byte_cnt_inc == req) state_d = DRAIN;
                    end
                end
            end else if (sclk_fall) begin
                if (state_q == DATA && cmd_q == CMD_RD) begin
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end else begin
                    miso_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 2'd0;
            rx_q       <= '0;
            cmd_q      <= '0;
            tx_q       <= '0;
            shadow_q   <= '0;
            duty_q     <= '0;
            load_q     <= '0;
            err_q      <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            rx_q       <= rx_d;
            cmd_q      <= cmd_d;
            tx_q       <= tx_d;
            shadow_q   <= shadow_d;
            duty_q     <= duty_d;
            load_q     <= load_d;
            err_q      <= err_d;
            miso_q     <= miso_d;
        end
    end

    assign duty_r    = duty_q[CH_R];
    assign duty_g    = duty_q[CH_G];
    assign duty_b    = duty_q[CH_B];
    assign load_r    = load_q[CH_R];
    assign load_g    = load_q[CH_G];
    assign load_b    = load_q[CH_B];
    assign frame_err = err_q;
    assign spi_miso  = miso_q;

endmodule

// File: tb/tb_spi_rgb_regs.sv
// Scoreboarded bench: host SPI driver pushes expected commits/readback, monitor pops on DUT strobes.
module tb_spi_rgb_regs;

    localparam int SYNC = 2;
    localparam int HALF = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_sclk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic [7:0] duty_r, duty_g, duty_b;
    logic       load_r, load_g, load_b, frame_err;

    spi_rgb_regs #(.SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_sclk  (spi_sclk),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .duty_r    (duty_r),
        .duty_g    (duty_g),
        .duty_b    (duty_b),
        .load_r    (load_r),
        .load_g    (load_g),
        .load_b    (load_b),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [2:0] mask;
        logic       err;
        logic [7:0] r, g, b;
        int         cyc;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] rd_exp[$];
    logic [7:0] rd_got[$];
    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] md[3];
    logic [7:0] mon[3];
    ev_t        mon_e;

    logic [7:0] frm[8];
    int         frm_n;
    int         frm_part;
    logic [7:0] frm_pb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (load_r | load_g | load_b | frame_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {28'd0, frame_err, load_b, load_g, load_r}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("load_mask", {29'd0, load_b, load_g, load_r}, {29'd0, mon_e.mask});
                    chk("frame_err", {31'd0, frame_err}, {31'd0, mon_e.err});
                    chk("event_latency", 32'(cyc - mon_e.cyc), 32'(SYNC + 1));
                    mon[0] = mon_e.r;
                    mon[1] = mon_e.g;
                    mon[2] = mon_e.b;
                end
            end
            chk("duty_r", {24'd0, duty_r}, {24'd0, mon[0]});
            chk("duty_g", {24'd0, duty_g}, {24'd0, mon[1]});
            chk("duty_b", {24'd0, duty_b}, {24'd0, mon[2]});
            while (rd_got.size() > 0 && rd_exp.size() > 0)
                chk("miso_byte", {24'd0, rd_got.pop_front()}, {24'd0, rd_exp.pop_front()});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xfer_bits(input logic [7:0] b, input int nbits, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = b[7-i];
            tick(HALF);
            got = {got[6:0], spi_miso};
            spi_sclk = 1'b1;
            tick(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    // Reference model: outcome of a frame derived from its byte list alone.
    task automatic do_frame();
        logic [7:0] c, got;
        ev_t        e;
        logic       have_ev;
        int         ch;
        c = frm[0];
        e.mask = 3'b000;
        e.err = 1'b0;
        have_ev = 1'b1;
        for (int i = 0; i < frm_n; i++)
            rd_exp.push_back((c == 8'h00 && i >= 1 && i <= 3) ? md[i-1] : 8'h00);
        case (c)
            8'h80: begin
                if (frm_n >= 4 && frm_part == 0) begin
                    md[0] = frm[1]; md[1] = frm[2]; md[2] = frm[3];
                    e.mask = 3'b111;
                end else e.err = 1'b1;
            end
            8'h81, 8'h82, 8'h83: begin
                ch = int'(c - 8'h81);
                if (frm_n >= 2 && frm_part == 0) begin
                    md[ch] = frm[1];
                    e.mask = 3'(1 << ch);
                end else e.err = 1'b1;
            end
            8'h00:   have_ev = 1'b0;
            default: e.err = 1'b1;
        endcase
        e.r = md[0]; e.g = md[1]; e.b = md[2];
        spi_cs_n = 1'b0;
        for (int i = 0; i < frm_n; i++) begin
            xfer_bits(frm[i], 8, got);
            rd_got.push_back(got);
        end
        if (frm_part > 0) xfer_bits(frm_pb, frm_part, got);
        tick(HALF);
        spi_cs_n = 1'b1;
        e.cyc = cyc;
        if (have_ev) exp_q.push_back(e);
        tick(8);
    endtask

    task automatic frame4(input int n, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3, input int part);
        frm[0] = b0; frm[1] = b1; frm[2] = b2; frm[3] = b3;
        frm_n = n;
        frm_part = part;
        frm_pb = 8'hA8;
        do_frame();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] got;
        int r;
        for (int i = 0; i < 3; i++) begin md[i] = 8'h00; mon[i] = 8'h00; end
        tick(3);
        chk("rst_duty_r", {24'd0, duty_r}, 32'd0);
        chk("rst_duty_g", {24'd0, duty_g}, 32'd0);
        chk("rst_duty_b", {24'd0, duty_b}, 32'd0);
        chk("rst_loads", {29'd0, load_b, load_g, load_r}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_miso", {31'd0, spi_miso}, 32'd0);
        rst_n = 1'b1;
        tick(4);

        frame4(4, 8'h80, 8'h12, 8'h34, 8'h56, 0);
        frame4(2, 8'h82, 8'hA5, 8'h00, 8'h00, 0);
        frame4(3, 8'h80, 8'h11, 8'h22, 8'h00, 0);
        frame4(4, 8'h00, 8'hFF, 8'hFF, 8'hFF, 0);
        frame4(2, 8'h7F, 8'hFF, 8'h00, 8'h00, 0);
        frame4(1, 8'h81, 8'h00, 8'h00, 8'h00, 5);
        frame4(2, 8'h81, 8'h01, 8'h00, 8'h00, 0);
        frame4(4, 8'h80, 8'h9A, 8'hBC, 8'hDE, 0);

        // Reset in the middle of a write-all frame, cs_n still low when reset lifts.
        spi_cs_n = 1'b0;
        xfer_bits(8'h80, 8, got);
        xfer_bits(8'h12, 3, got);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin md[i] = 8'h00; mon[i] = 8'h00; end
        #1;
        chk("async_rst_duty_r", {24'd0, duty_r}, 32'd0);
        chk("async_rst_duty_g", {24'd0, duty_g}, 32'd0);
        chk("async_rst_duty_b", {24'd0, duty_b}, 32'd0);
        tick(4);
        rst_n = 1'b1;
        tick(2);
        xfer_bits(8'h34, 5, got);
        tick(HALF);
        spi_cs_n = 1'b1;
        tick(12);
        frame4(4, 8'h80, 8'h21, 8'h43, 8'h65, 0);
        frame4(4, 8'h00, 8'h00, 8'h00, 8'h00, 0);

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 5);
            case (r)
                0:       frm[0] = 8'h80;
                1, 2, 3: frm[0] = 8'h80 + 8'(r);
                4:       frm[0] = 8'h00;
                default: frm[0] = 8'($urandom);
            endcase
            for (int i = 1; i < 8; i++) frm[i] = 8'($urandom);
            frm_n = 1 + $urandom_range(0, 5);
            frm_part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            frm_pb = 8'($urandom);
            do_frame();
        end

        tick(20);
        chk("events_drained", 32'(exp_q.size()), 32'd0);
        chk("readback_drained", 32'(rd_exp.size() + rd_got.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
